// File: rtl/vu_pkg.sv
// vu_pkg: shared types and defaults for the VU meter frame scheduler.
// Holds the scheduler state enum, default widths and the scale width helper.
package vu_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int LEDS_DEF     = 20;
  localparam int ADDR_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT_RDY,
    WAIT_ACK
  } vu_state_t;

  // Product peak*LEDS fits in SAMPLE_W+ADDR bits because LEDS < 2**ADDR.
  function automatic int scale_w(input int sample_w, input int addr);
    return sample_w + addr;
  endfunction

endpackage

// File: rtl/vu_level_scale.sv
// vu_level_scale: peak magnitude -> LED count, ceil(peak*LEDS/2**SAMPLE_W).
// Ports: peak_cap (in, SAMPLE_W), level_raw (out, ADDR, saturated at LEDS).
module vu_level_scale
  import vu_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int LEDS     = LEDS_DEF,
  parameter int ADDR     = ADDR_DEF
) (
  input  logic [SAMPLE_W-1:0] peak_cap,
  output logic [ADDR-1:0]     level_raw
);

  localparam int W = scale_w(SAMPLE_W, ADDR);
  localparam logic [W-1:0] RND  = W'((1 << SAMPLE_W) - 1);
  localparam logic [W-1:0] FULL = W'(LEDS);

  logic [W-1:0] prod;
  logic [W-1:0] quo;

  // Adding 2**SAMPLE_W-1 before the shift turns the floor into a ceiling,
  // so any nonzero peak lights at least one LED.
  always_comb begin
    prod      = W'(peak_cap) * FULL;
    quo       = (prod + RND) >> SAMPLE_W;
    level_raw = (quo > FULL) ? FULL[ADDR-1:0] : quo[ADDR-1:0];
  end

endmodule

// File: rtl/vu_frame_scheduler.sv
// vu_frame_scheduler: per-frame peak capture, LED scaling, fall ballistics
// and one i_send/i_value handshake per frame into npxl_controller.
// Ports: i_clk, i_rst (sync, active-high), i_sample_valid, i_sample,
//   i_npxl_rdy; o_send (pulse), o_value, o_overrun (sticky), o_ack_err.
// Option: define VU_SKIP_UNCHANGED_EN to skip sends of an unchanged level.
module vu_frame_scheduler
  import vu_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int LEDS         = LEDS_DEF,
  parameter int ADDR         = ADDR_DEF,
  parameter int FRAME_CYCLES = 1000000,
  parameter int DECAY_STEP   = 1,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_npxl_rdy,
  output logic                o_send,
  output logic [ADDR-1:0]     o_value,
  output logic                o_overrun,
  output logic                o_ack_err
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST     = CW'(FRAME_CYCLES - 1);
  localparam logic [AW-1:0]   ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [ADDR-1:0] STEP     = ADDR'(DECAY_STEP);

  vu_state_t state;
  vu_state_t state_nx;

  logic [CW-1:0]       cnt;
  logic                tick;
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] peak_in;
  logic [SAMPLE_W-1:0] peak_cap;
  logic [ADDR-1:0]     level_raw;
  logic [ADDR-1:0]     disp;
  logic [ADDR-1:0]     disp_dec;
  logic [ADDR-1:0]     disp_nx;
  logic [AW-1:0]       ack_cnt;
  logic                ack_last;
  logic                skip;

  assign tick     = (cnt == LAST);
  assign ack_last = (ack_cnt == ACK_LAST);
  assign o_value  = disp;

  // Running max including this cycle's sample, so a tick-cycle sample
  // lands in the frame that is closing.
  always_comb begin
    peak_in = peak;
    if (i_sample_valid && (i_sample > peak)) begin
      peak_in = i_sample;
    end
  end

  vu_level_scale #(
    .SAMPLE_W (SAMPLE_W),
    .LEDS     (LEDS),
    .ADDR     (ADDR)
  ) u_scale (
    .peak_cap  (peak_cap),
    .level_raw (level_raw)
  );

  always_comb begin
    disp_dec = (disp > STEP) ? disp - STEP : '0;
    if (level_raw >= disp) begin
      disp_nx = level_raw;
    end else if (level_raw > disp_dec) begin
      disp_nx = level_raw;
    end else begin
      disp_nx = disp_dec;
    end
  end

`ifdef VU_SKIP_UNCHANGED_EN
  logic sent_any;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sent_any <= 1'b0;
    end else if (o_send) begin
      sent_any <= 1'b1;
    end
  end

  // disp always equals the last value handed to the controller once a
  // send has happened, since it only moves in CALC.
  assign skip = sent_any && (disp_nx == disp);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A tick outside IDLE is an overrun: that frame's peak is dropped
  // but the accumulator still restarts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak      <= '0;
      peak_cap  <= '0;
      o_overrun <= 1'b0;
    end else if (tick) begin
      peak <= '0;
      if (state == IDLE) begin
        peak_cap <= peak_in;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_sample_valid) begin
      peak <= peak_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      disp <= '0;
    end else if (state == CALC) begin
      disp <= disp_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_cnt <= '0;
    end else if (state == WAIT_ACK) begin
      ack_cnt <= ack_cnt + 1'b1;
    end else begin
      ack_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (tick) state_nx = CALC;
      end
      CALC: begin
        state_nx = skip ? IDLE : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (i_npxl_rdy) state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!i_npxl_rdy || ack_last) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    o_send    = (state == WAIT_RDY) && i_npxl_rdy;
    o_ack_err = (state == WAIT_ACK) && i_npxl_rdy && ack_last;
  end

endmodule
